// File: rtl/resp_merger.sv
// Merges per-bank read responses back into issue order using a FIFO of bank indices.
// Optional sticky error checking is enabled with the RESP_MERGER_ERR_EN macro.
module resp_merger #(
  parameter int BANKS      = 3,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic [$clog2(BANKS)-1:0]        issue_bank,
  output logic                            issue_ready,
  input  logic [BANKS-1:0]                bank_rsp_valid,
  input  logic [BANKS*DATA_WIDTH-1:0]     bank_rsp_data,
  output logic [BANKS-1:0]                bank_rsp_ready,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  input  logic                            rsp_ready,
  output logic [$clog2(DEPTH+1)-1:0]      outstanding
`ifdef RESP_MERGER_ERR_EN
  ,
  output logic                            err
`endif
);

  localparam int LOG2_BANK = $clog2(BANKS);
  localparam int CNT_W     = $clog2(DEPTH+1);
  localparam int PTR_W     = $clog2(DEPTH);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high
  // at the rising edge; valid never depends combinationally on the matching ready.
  logic [LOG2_BANK-1:0]  order_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [BANKS-1:0]      hold_valid;
  logic [DATA_WIDTH-1:0] hold_data [BANKS];
  logic [LOG2_BANK-1:0]  head_bank;
  logic                  head_held;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  bank_ok;
  logic                  push;
  logic                  pop;

  assign head_bank = order_mem[rd_ptr];

  // Explicit compare-mux so an out-of-range head index never reads past the array.
  always_comb begin
    head_held = 1'b0;
    head_data = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (head_bank == LOG2_BANK'(i)) begin
        head_held = hold_valid[i];
        head_data = hold_data[i];
      end
    end
  end

`ifdef RESP_MERGER_ERR_EN
  assign bank_ok = {1'b0, issue_bank} < (LOG2_BANK+1)'(BANKS);
`else
  assign bank_ok = 1'b1;
`endif

  assign issue_ready    = count < CNT_W'(DEPTH);
  assign bank_rsp_ready = ~hold_valid;
  assign rsp_valid      = (count != '0) && head_held;
  assign rsp_data       = head_data;
  assign outstanding    = count;
  assign push           = issue_valid && issue_ready && bank_ok;
  assign pop            = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      order_mem[wr_ptr] <= issue_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_valid <= '0;
      for (int i = 0; i < BANKS; i++) begin
        hold_data[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A popped slot had ready low this cycle, so capture and clear never collide.
      for (int i = 0; i < BANKS; i++) begin
        if (bank_rsp_valid[i] && !hold_valid[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= bank_rsp_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (pop && (head_bank == LOG2_BANK'(i))) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef RESP_MERGER_ERR_EN
  logic [BANKS-1:0] has_entry;
  logic [PTR_W-1:0] slot_off;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    has_entry = '0;
    slot_off  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_off = PTR_W'(j) - rd_ptr;
      if ({1'b0, slot_off} < count) begin
        for (int i = 0; i < BANKS; i++) begin
          if (order_mem[j] == LOG2_BANK'(i)) begin
            has_entry[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((issue_valid && issue_ready && !bank_ok) ||
                 (|(bank_rsp_valid & ~hold_valid & ~has_entry))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/resp_merger.md
RESP_MERGER -- requirements
Module: resp_merger

Interface
REQ-001 SHALL have parameter BANKS, default 3: number of memory banks fed by the address decoder.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: read-data width per bank.
REQ-003 SHALL have parameter DEPTH, default 4: maximum outstanding requests; power of two, at least 2.
REQ-004 SHALL derive localparam LOG2_BANK = $clog2(BANKS) and CNT_W = $clog2(DEPTH+1).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port issue_valid, input, 1: a request was sent to the bank given by issue_bank.
REQ-008 SHALL have port issue_bank, input, LOG2_BANK: bank index of the issued request (decoder bank index).
REQ-009 SHALL have port issue_ready, output, 1: the order FIFO can accept an issue.
REQ-010 SHALL have port bank_rsp_valid, input, BANKS: per-bank read response valid.
REQ-011 SHALL have port bank_rsp_data, input, BANKS*DATA_WIDTH: bank i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port bank_rsp_ready, output, BANKS: per-bank response accept.
REQ-013 SHALL have port rsp_valid, output, 1: merged response valid, in issue order.
REQ-014 SHALL have port rsp_data, output, DATA_WIDTH: merged response data.
REQ-015 SHALL have port rsp_ready, input, 1: consumer accepts the merged response.
REQ-016 SHALL have port outstanding, output, CNT_W: current order-FIFO occupancy.

Function
REQ-017 SHALL hold an order FIFO of DEPTH bank indices, with read and write pointers wrapping modulo DEPTH.
REQ-018 SHALL set issue_ready = (outstanding < DEPTH); it is registered-state based, and a same-cycle pop does not raise it.
REQ-019 SHALL push issue_bank when issue_valid && issue_ready; issue_valid while not ready is ignored (dropped, no push).
REQ-020 SHALL keep one holding register per bank (hold_valid[i], hold_data[i]) and set bank_rsp_ready[i] = !hold_valid[i].
REQ-021 SHALL capture bank_rsp_data[i] into the holding register when bank_rsp_valid[i] && bank_rsp_ready[i].
REQ-022 SHALL make hold_valid[i] visible the next cycle; a bank response at cycle N gives rsp_valid at N+1 at the earliest.
REQ-023 SHALL drive rsp_valid = (outstanding != 0) && hold_valid[head_bank], and rsp_data = hold_data[head_bank].
REQ-024 SHALL hold rsp_data stable while rsp_valid && !rsp_ready.
REQ-025 SHALL, on a pop (rsp_valid && rsp_ready), clear hold_valid[head_bank] and advance the read pointer.
REQ-026 SHALL not let a holding register be refilled in the cycle it is popped, because its ready was low that cycle.
REQ-027 SHALL, on a simultaneous push and pop, leave outstanding unchanged and update both pointers.
REQ-028 SHALL not output a response held by a non-head bank until that bank reaches the head; later banks stall behind the head.
REQ-029 SHALL leave bank_rsp_valid from a bank with no FIFO entry captured; the design does not police this (see REQ-035).

Reset
REQ-030 SHALL, when rst is high at a clock edge, clear both pointers, set outstanding = 0, clear all hold_valid and set rsp_valid = 0.
REQ-031 SHALL make issue_ready = 1 and bank_rsp_ready = all-ones in the first cycle after reset.
REQ-032 SHALL discard a reset asserted mid-operation: all in-flight order entries and held data are lost, and there is no partial completion.
REQ-033 SHALL drive rsp_data as don't-care while rsp_valid = 0; it resets to zero.

Configuration
REQ-034 SHALL, when macro RESP_MERGER_ERR_EN is defined, add port err (output, 1): a sticky flag cleared only by rst.
REQ-035 SHALL, with RESP_MERGER_ERR_EN, set err on issue_bank >= BANKS at a push (the issue is dropped), and on bank_rsp_valid[i] capture when bank i has no entry in the FIFO.
REQ-036 SHALL, without RESP_MERGER_ERR_EN, have no err port and no check logic; out-of-range issue_bank is undefined behaviour.

Verification
REQ-037 SHALL cover in-order return: issue banks 0,1,2 in turn, banks respond 0xA0,0xA1,0xA2 in order with rsp_ready=1 -> rsp_data 0xA0,0xA1,0xA2 on consecutive cycles, outstanding returns to 0.
REQ-038 SHALL cover out-of-order return: issue 2 then 0, bank 0 responds 0x11 first and bank 2 responds 0x22 two cycles later -> rsp_valid low until bank 2 data is held, then 0x22 followed by 0x11.
REQ-039 SHALL cover full: DEPTH=4, four issues with no responses -> issue_ready=0, outstanding=4; a fifth issue_valid is dropped; one pop -> issue_ready=1 the next cycle.
REQ-040 SHALL cover backpressure: rsp_ready=0 with head data 0x5A held -> rsp_valid=1 and 0x5A stable, bank_rsp_ready for that bank=0, second bank response stalled until the pop.
REQ-041 SHALL cover mid-operation reset: with 3 outstanding and 2 held, pulse rst for one cycle -> next cycle outstanding=0, rsp_valid=0, issue_ready=1, bank_rsp_ready=3'b111.
REQ-042 SHALL cover the error flag with RESP_MERGER_ERR_EN: issue_bank=3 with BANKS=3 -> err=1 from the next cycle, no push; err stays 1 until rst.
